// File: rtl/linked_list_multi_fifo.sv
// Shared-storage multi-queue FIFO: NUM_FIFOS linked-list queues plus a free
// list over one DEPTH-entry buffer, with simultaneous push and pop.
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   push/push_sel/data_in enqueue request
//   pop/pop_sel           dequeue request
//   full, empty, count    occupancy (count packed per queue)
//   free_count            number of free entries
//   data_out/_vld         registered pop data
//   err_overflow          sticky rejected-push flag
//   err_underflow         sticky rejected-pop flag
module linked_list_multi_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int NUM_FIFOS = 2,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int SEL_WIDTH = $clog2(NUM_FIFOS),
    parameter int CNT_WIDTH = $clog2(DEPTH+1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [SEL_WIDTH-1:0]           push_sel,
    input  logic [WIDTH-1:0]               data_in,
    input  logic                           pop,
    input  logic [SEL_WIDTH-1:0]           pop_sel,
    output logic                           full,
    output logic [NUM_FIFOS-1:0]           empty,
    output logic [NUM_FIFOS*CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0]           free_count,
    output logic [WIDTH-1:0]               data_out,
    output logic                           data_out_vld,
    output logic                           err_overflow,
    output logic                           err_underflow
);

    logic [WIDTH-1:0]     mem  [DEPTH];
    logic [PTR_WIDTH-1:0] nxt  [DEPTH];
    logic [PTR_WIDTH-1:0] head [NUM_FIFOS];
    logic [PTR_WIDTH-1:0] tail [NUM_FIFOS];
    logic [CNT_WIDTH-1:0] cnt  [NUM_FIFOS];
    logic [PTR_WIDTH-1:0] free_head;
    logic [PTR_WIDTH-1:0] free_tail;
    logic [CNT_WIDTH-1:0] free_cnt;

    logic                 push_ok;
    logic                 pop_ok;
    logic                 same_q;
    logic [PTR_WIDTH-1:0] h;

    always_comb begin
        full       = (free_cnt == '0);
        free_count = free_cnt;
        empty      = '0;
        count      = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            empty[i] = (cnt[i] == '0);
            count[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
        end
    end

    // Out-of-range selects are masked before indexing matters.
    assign push_ok = push && !full && (32'(push_sel) < NUM_FIFOS);
    assign pop_ok  = pop && (32'(pop_sel) < NUM_FIFOS) && !empty[pop_sel];
    assign same_q  = push_ok && pop_ok && (push_sel == pop_sel);
    assign h       = head[pop_sel];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[free_head] <= data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                nxt[i] <= PTR_WIDTH'(i + 1);
            for (int i = 0; i < NUM_FIFOS; i++) begin
                head[i] <= '0;
                tail[i] <= '0;
                cnt[i]  <= '0;
            end
            free_head     <= '0;
            free_tail     <= PTR_WIDTH'(DEPTH - 1);
            free_cnt      <= CNT_WIDTH'(DEPTH);
            data_out      <= '0;
            data_out_vld  <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            data_out_vld <= pop_ok;
            if (push && !push_ok)
                err_overflow <= 1'b1;
            if (pop && !pop_ok)
                err_underflow <= 1'b1;
            free_cnt <= free_cnt + CNT_WIDTH'(pop_ok) - CNT_WIDTH'(push_ok);

            if (push_ok) begin
                // Last free entry taken while a pop refills: pop sets free_head.
                if (!(pop_ok && free_cnt == CNT_WIDTH'(1)))
                    free_head <= nxt[free_head];
                tail[push_sel] <= free_head;
                if (cnt[push_sel] == '0 ||
                    (same_q && cnt[push_sel] == CNT_WIDTH'(1)))
                    head[push_sel] <= free_head;
                else
                    nxt[tail[push_sel]] <= free_head;
            end

            if (pop_ok) begin
                data_out <= mem[h];
                if (!(same_q && cnt[pop_sel] == CNT_WIDTH'(1)))
                    head[pop_sel] <= nxt[h];
                // Free list empty after this cycle's push: h starts it anew.
                if (free_cnt == CNT_WIDTH'(push_ok))
                    free_head <= h;
                else
                    nxt[free_tail] <= h;
                free_tail <= h;
            end

            for (int i = 0; i < NUM_FIFOS; i++) begin
                if (push_ok && push_sel == SEL_WIDTH'(i) &&
                    !(pop_ok && pop_sel == SEL_WIDTH'(i)))
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                else if (pop_ok && pop_sel == SEL_WIDTH'(i) &&
                         !(push_ok && push_sel == SEL_WIDTH'(i)))
                    cnt[i] <= cnt[i] - CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_linked_list_multi_fifo.sv
// Directed and reference-model checks for linked_list_multi_fifo
// (DEPTH=4, NUM_FIFOS=2, WIDTH=8).
module tb_linked_list_multi_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       push;
    logic [0:0] push_sel;
    logic [7:0] data_in;
    logic       pop;
    logic [0:0] pop_sel;
    logic       full;
    logic [1:0] empty;
    logic [5:0] count;
    logic [2:0] free_count;
    logic [7:0] data_out;
    logic       data_out_vld;
    logic       err_overflow;
    logic       err_underflow;

    int errors = 0;
    int checks = 0;

    logic [7:0] mq0 [$];
    logic [7:0] mq1 [$];

    linked_list_multi_fifo #(
        .WIDTH(8), .DEPTH(4), .NUM_FIFOS(2)
    ) dut (
        .clk(clk), .rst(rst),
        .push(push), .push_sel(push_sel), .data_in(data_in),
        .pop(pop), .pop_sel(pop_sel),
        .full(full), .empty(empty), .count(count),
        .free_count(free_count),
        .data_out(data_out), .data_out_vld(data_out_vld),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic p, input logic ps, input logic [7:0] d,
                      input logic q, input logic qs);
        push     = p;
        push_sel = ps;
        data_in  = d;
        pop      = q;
        pop_sel  = qs;
        cyc();
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_empty"}, 32'(empty), 3);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_free"}, 32'(free_count), 4);
        chk({tag, "_dout"}, 32'(data_out), 0);
        chk({tag, "_vld"}, 32'(data_out_vld), 0);
        chk({tag, "_ovf"}, 32'(err_overflow), 0);
        chk({tag, "_unf"}, 32'(err_underflow), 0);
    endtask

    initial begin
        rst = 1'b0;
        push = 1'b0; push_sel = '0; data_in = '0;
        pop = 1'b0; pop_sel = '0;
        #12;
        chk_reset("rst");
        rst = 1'b1;
        cyc();

        // basic ordering across two queues
        op(1, 0, 8'hA1, 0, 0);
        op(1, 1, 8'hB2, 0, 0);
        op(1, 0, 8'hA3, 0, 0);
        chk("cnt_q0_2", 32'(count[2:0]), 2);
        chk("cnt_q1_1", 32'(count[5:3]), 1);
        chk("free_1", 32'(free_count), 1);
        chk("full_0", 32'(full), 0);
        op(0, 0, 0, 1, 0);
        chk("pop_a1", 32'(data_out), 32'h A1);
        chk("pop_a1_vld", 32'(data_out_vld), 1);
        op(0, 0, 0, 1, 0);
        chk("pop_a3", 32'(data_out), 32'h A3);
        chk("pop_a3_vld", 32'(data_out_vld), 1);
        chk("empty_q0", 32'(empty), 1);
        cyc();
        chk("idle_vld", 32'(data_out_vld), 0);
        chk("idle_hold", 32'(data_out), 32'h A3);
        op(0, 0, 0, 1, 1);
        chk("pop_b2", 32'(data_out), 32'h B2);
        chk("all_free", 32'(free_count), 4);

        // fill q1, then push while full with a pop
        for (int i = 0; i < 4; i++)
            op(1, 1, 8'(8'h10 + i), 0, 0);
        chk("fill_full", 32'(full), 1);
        chk("fill_free", 32'(free_count), 0);
        chk("fill_cnt", 32'(count[5:3]), 4);
        chk("fill_ovf0", 32'(err_overflow), 0);
        op(1, 0, 8'h55, 1, 1);
        chk("ovf_pop", 32'(data_out), 32'h10);
        chk("ovf_vld", 32'(data_out_vld), 1);
        chk("ovf_flag", 32'(err_overflow), 1);
        chk("ovf_q0_empty", 32'(empty[0]), 1);
        chk("ovf_free", 32'(free_count), 1);
        chk("ovf_cnt", 32'(count), 32'(6'b011_000));

        // underflow
        op(0, 0, 0, 1, 0);
        chk("unf_flag", 32'(err_underflow), 1);
        chk("unf_vld", 32'(data_out_vld), 0);
        chk("unf_cnt", 32'(count), 32'(6'b011_000));
        chk("unf_hold", 32'(data_out), 32'h10);
        cyc();
        chk("unf_sticky", 32'(err_underflow), 1);
        for (int i = 1; i < 4; i++) begin
            op(0, 0, 0, 1, 1);
            chk("drain_q1", 32'(data_out), 32'(8'h10 + i));
        end

        // same-queue push and pop at count 1
        op(1, 0, 8'h11, 0, 0);
        op(1, 0, 8'h22, 1, 0);
        chk("same_pop", 32'(data_out), 32'h11);
        chk("same_cnt", 32'(count[2:0]), 1);
        chk("same_free", 32'(free_count), 3);
        op(0, 0, 0, 1, 0);
        chk("same_next", 32'(data_out), 32'h22);
        chk("same_vld", 32'(data_out_vld), 1);
        chk("same_empty", 32'(empty), 3);

        // random accepted traffic vs reference queues
        for (int c = 0; c < 1000; c++) begin
            logic       dp, dq, ps, qs;
            logic [7:0] d, exp;
            int         tot;
            tot = mq0.size() + mq1.size();
            ps  = 1'($urandom_range(0, 1));
            qs  = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            dp  = (tot < 4) && ($urandom_range(0, 3) != 0);
            dq  = ((qs ? mq1.size() : mq0.size()) > 0) &&
                  ($urandom_range(0, 3) != 0);
            exp = '0;
            if (dq)
                exp = qs ? mq1[0] : mq0[0];
            op(dp, ps, d, dq, qs);
            if (dq) begin
                if (qs) void'(mq1.pop_front());
                else    void'(mq0.pop_front());
                chk("rnd_data", 32'(data_out), 32'(exp));
            end
            chk("rnd_vld", 32'(data_out_vld), 32'(dq));
            if (dp) begin
                if (ps) mq1.push_back(d);
                else    mq0.push_back(d);
            end
            chk("rnd_inv", 32'(free_count) + 32'(count[2:0]) +
                32'(count[5:3]), 4);
            chk("rnd_cnt0", 32'(count[2:0]), 32'(mq0.size()));
            chk("rnd_cnt1", 32'(count[5:3]), 32'(mq1.size()));
        end
        chk("sticky_ovf", 32'(err_overflow), 1);
        chk("sticky_unf", 32'(err_underflow), 1);

        // asynchronous reset mid-burst
        op(1, 0, 8'h33, 0, 0);
        push = 1'b1; push_sel = 1'b1; data_in = 8'h44;
        pop = 1'b1; pop_sel = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_reset("async");
        push = 1'b0;
        pop  = 1'b0;
        #2;
        rst = 1'b1;
        cyc();
        op(1, 1, 8'h7E, 0, 0);
        chk("post_cnt", 32'(count[5:3]), 1);
        op(0, 0, 0, 1, 1);
        chk("post_pop", 32'(data_out), 32'h7E);
        chk("post_vld", 32'(data_out_vld), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/linked_list_multi_fifo.md
# linked_list_multi_fifo

- Shared-storage multi-queue FIFO: NUM_FIFOS logical queues share one DEPTH-entry data buffer.
- Storage is managed by per-queue linked lists plus a free list.
- Next generation of the two-queue shared FIFO: adds simultaneous push and pop to any queues, per-queue occupancy counts, a registered pop-data output with valid, and sticky protocol-error flags.
- Sits between producers and a per-channel consumer; its ordering contract is checked against one shift-register FIFO per queue.

## Interface
Parameters:
- WIDTH, 8, data word width
- DEPTH, 4, shared entries; power of two, ≥2
- NUM_FIFOS, 2, logical queues, ≥2
- PTR_WIDTH, $clog2(DEPTH), entry pointer width
- SEL_WIDTH, $clog2(NUM_FIFOS), queue select width
- CNT_WIDTH, $clog2(DEPTH+1), occupancy count width

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- push  input  1  enqueue data_in to queue push_sel
- push_sel  input  SEL_WIDTH  target queue of push
- data_in  input  WIDTH  push data
- pop  input  1  dequeue head of queue pop_sel
- pop_sel  input  SEL_WIDTH  source queue of pop
- full  output  1  no free entries
- empty  output  NUM_FIFOS  bit i set when queue i holds 0 entries
- count  output  NUM_FIFOS*CNT_WIDTH  occupancy of queue i at bits [i*CNT_WIDTH +: CNT_WIDTH]
- free_count  output  CNT_WIDTH  free entries
- data_out  output  WIDTH  registered pop data
- data_out_vld  output  1  data_out holds the data of an accepted pop
- err_overflow  output  1  sticky: push attempted while full
- err_underflow  output  1  sticky: pop attempted on empty queue or out-of-range pop_sel

## Operation
- State:
  - data array: DEPTH × WIDTH
  - next array: DEPTH × PTR_WIDTH
  - per-queue head, tail and count
  - free list: head, tail, free_count
- Reset (rst low, asynchronous):
  - free list = 0→1→…→DEPTH-1, free head 0, free tail DEPTH-1, free_count = DEPTH
  - all queue counts 0; empty all ones; full 0
  - data_out 0, data_out_vld 0, error flags 0
  - data array contents are not reset
- Acceptance uses registered state only:
  - push accepted iff !full and push_sel < NUM_FIFOS
  - pop accepted iff !empty[pop_sel] and pop_sel < NUM_FIFOS
- Accepted push:
  - entry f = free head is written with data_in
  - f is linked after the tail of push_sel, or becomes its head if the queue was empty; tail = f
  - free head advances
- Accepted pop:
  - entry h = head of pop_sel; data[h] loads data_out; head advances to next[h]
  - h is appended to the free-list tail
- Simultaneous push and pop, both accepted, any queue combination:
  - free_count unchanged; pushing queue count +1, popping queue count -1, net 0 if same queue
  - same queue with count 1: pop returns the old entry; the pushed entry becomes both head and tail
- Rejected operations:
  - rejected push: no state change except err_overflow
  - rejected pop: no state change except err_underflow; data_out_vld 0 next cycle
- Full and pop in the same cycle: push is still rejected and err_overflow sets; the pop proceeds.
- Combinational outputs:
  - full = (free_count == 0)
  - empty[i] = (count[i] == 0)
- Invariant: free_count + Σcount = DEPTH at all times.
- Error flags clear only on reset.

## Timing
- Push accepted at edge N: count, empty, full and free_count reflect it after edge N.
- Data is poppable from cycle N+1; push-to-pop bypass in the same cycle is not supported.
- Pop accepted in cycle N: data_out and data_out_vld = 1 valid in cycle N+1. data_out holds its value when data_out_vld is 0.
- Sustained throughput: one push plus one pop per cycle.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.
- Reset deassertion is synchronised externally; the first operation is accepted on the first edge with rst high.

## Test plan
- Reset, then push 0xA1 to q0, 0xB2 to q1, 0xA3 to q0 → count q0=2, q1=1, free_count=1. Pop q0 twice → data_out 0xA1 then 0xA3, each with data_out_vld=1 one cycle after its pop.
- Fill with DEPTH pushes to q1 → full=1. Push 0x55 to q0 together with a pop of q1 → push dropped, err_overflow=1; q0 stays empty; free_count=1 next cycle.
- Pop q0 while empty → err_underflow=1, data_out_vld=0, counts unchanged. The flag stays set until rst is taken low.
- q0 holds one entry 0x11; same-cycle push 0x22 to q0 and pop q0 → data_out=0x11; count q0 stays 1; next pop returns 0x22.
- Interleave random accepted push/pop across queues for 1000 cycles:
  - per-queue output order matches a reference shift-register FIFO
  - free_count + Σcount = DEPTH every cycle
  - free-list wrap-around is exercised repeatedly
- Assert rst low mid-burst, asynchronously between edges → outputs at reset values before the next edge; after release, push 0x7E to q1 and pop → 0x7E returned.
